// File: rtl/alsu_cmd_driver.sv
// ALSU command driver: issues commands into a fixed-latency ALSU and
// returns results in order through a small FIFO.
// Optional macro ALSU_DRV_ERR_CNT_EN enables the invalid-result counter.
module alsu_cmd_driver #(
   parameter int DEPTH        = 4,
   parameter int ALSU_LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_opcode,
   input  logic signed [2:0] cmd_A,
   input  logic signed [2:0] cmd_B,
   input  logic [6:0]        cmd_ctrl,
   output logic [2:0]        alsu_opcode,
   output logic signed [2:0] alsu_A,
   output logic signed [2:0] alsu_B,
   output logic [6:0]        alsu_ctrl,
   input  logic signed [5:0] alsu_out,
   input  logic [15:0]       alsu_leds,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic signed [5:0] rsp_out,
   output logic              rsp_invalid,
   output logic [15:0]       err_cnt
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(ALSU_LATENCY + 2);
   localparam int OW = 8;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t                state, state_nx;
   logic [IW-1:0]         fl_cnt, fl_cnt_nx;
   logic                  rdy_en;
   logic [ALSU_LATENCY:0] tag;
   logic [IW-1:0]         in_flight;
   logic [6:0]            mem [DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         count;
   logic                  issue, push, push_ok, pop;
   logic                  empty, full;
   logic [OW-1:0]         occ;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign occ       = OW'(in_flight) + OW'(count);
   assign cmd_ready = rdy_en & (state != FLUSH) & ~flush
                    & (occ < OW'(DEPTH));
   assign issue     = cmd_valid & cmd_ready;
   assign push      = tag[ALSU_LATENCY];
   assign push_ok   = push & ~flush;
   assign empty     = (count == '0);
   assign full      = (count == CW'(DEPTH));
   assign rsp_valid = ~empty;
   assign pop       = rsp_valid & rsp_ready;
   assign rsp_out     = rsp_valid ? mem[rd_ptr][6:1] : '0;
   assign rsp_invalid = rsp_valid & mem[rd_ptr][0];

   // Hold off cmd_ready until the first edge after reset release
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdy_en <= 1'b0;
      else     rdy_en <= 1'b1;
   end

   // FSM state and flush-duration counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         fl_cnt <= '0;
      end else begin
         state  <= state_nx;
         fl_cnt <= fl_cnt_nx;
      end
   end

   // Next-state logic; flush from any state restarts the drain window
   always_comb begin
      state_nx  = state;
      fl_cnt_nx = fl_cnt;
      if (flush) begin
         state_nx  = FLUSH;
         fl_cnt_nx = '0;
      end else begin
         unique case (state)
            IDLE: if (cmd_valid) state_nx = RUN;
            RUN: begin
               if (!cmd_valid && in_flight == '0 && empty)
                  state_nx = IDLE;
            end
            FLUSH: begin
               if (fl_cnt == IW'(ALSU_LATENCY)) state_nx = IDLE;
               else fl_cnt_nx = fl_cnt + 1'b1;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // Registered ALSU drive: command on handshake, bubble otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alsu_opcode <= '0;
         alsu_A      <= '0;
         alsu_B      <= '0;
         alsu_ctrl   <= '0;
      end else if (issue) begin
         alsu_opcode <= cmd_opcode;
         alsu_A      <= cmd_A;
         alsu_B      <= cmd_B;
         alsu_ctrl   <= cmd_ctrl;
      end else begin
         alsu_opcode <= '0;
         alsu_A      <= '0;
         alsu_B      <= '0;
         alsu_ctrl   <= '0;
      end
   end

   // Valid-tag pipeline tracking issued commands through the ALSU
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        tag <= '0;
      else if (flush) tag <= '0;
      else            tag <= {tag[ALSU_LATENCY-1:0], issue};
   end

   // Count of tags currently set in the pipeline
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        in_flight <= '0;
      else if (flush) in_flight <= '0;
      else begin
         case ({issue, push})
            2'b10:   in_flight <= in_flight + 1'b1;
            2'b01:   in_flight <= in_flight - 1'b1;
            default: in_flight <= in_flight;
         endcase
      end
   end

   // Result FIFO storage; entries are {result, leds-nonzero}
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= {alsu_out, |alsu_leds};
   end

   // Result FIFO pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)     rd_ptr <= ptr_inc(rd_ptr);
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   a_no_overflow: assert property (
      @(posedge clk) disable iff (rst) !(push_ok && full && !pop));

`ifdef ALSU_DRV_ERR_CNT_EN
   // Saturating count of invalid results entering the FIFO
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_cnt <= '0;
      else if (push_ok && (|alsu_leds) && err_cnt != 16'hFFFF)
         err_cnt <= err_cnt + 16'd1;
   end
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_alsu_cmd_driver.sv
// Directed bench for alsu_cmd_driver with a 2-stage ALSU model.
// Expected err_cnt follows ALSU_DRV_ERR_CNT_EN.
module tb_alsu_cmd_driver;

   logic              clk;
   logic              rst;
   logic              flush;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [2:0]        cmd_opcode;
   logic signed [2:0] cmd_A;
   logic signed [2:0] cmd_B;
   logic [6:0]        cmd_ctrl;
   logic [2:0]        alsu_opcode;
   logic signed [2:0] alsu_A;
   logic signed [2:0] alsu_B;
   logic [6:0]        alsu_ctrl;
   logic signed [5:0] alsu_out;
   logic [15:0]       alsu_leds;
   logic              rsp_valid;
   logic              rsp_ready;
   logic signed [5:0] rsp_out;
   logic              rsp_invalid;
   logic [15:0]       err_cnt;

`ifdef ALSU_DRV_ERR_CNT_EN
   localparam logic [15:0] EXP_ERR = 16'd1;
`else
   localparam logic [15:0] EXP_ERR = 16'd0;
`endif

   int checks   = 0;
   int failures = 0;

   alsu_cmd_driver #(.DEPTH(4), .ALSU_LATENCY(2)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_opcode(cmd_opcode), .cmd_A(cmd_A), .cmd_B(cmd_B),
      .cmd_ctrl(cmd_ctrl),
      .alsu_opcode(alsu_opcode), .alsu_A(alsu_A), .alsu_B(alsu_B),
      .alsu_ctrl(alsu_ctrl),
      .alsu_out(alsu_out), .alsu_leds(alsu_leds),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_out(rsp_out), .rsp_invalid(rsp_invalid),
      .err_cnt(err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALSU model: AND, XOR, ADD(+cin), MUL; opcodes 6/7 invalid
   function automatic logic [21:0] alsu_f(input logic [2:0] op,
                                          input logic [2:0] a,
                                          input logic [2:0] b,
                                          input logic [6:0] c);
      logic [5:0]  ea, eb, o;
      logic [15:0] l;
      ea = {{3{a[2]}}, a};
      eb = {{3{b[2]}}, b};
      o  = '0;
      l  = '0;
      case (op)
         3'd0: o = ea & eb;
         3'd1: o = ea ^ eb;
         3'd2: o = ea + eb + {5'd0, c[6]};
         3'd3: o = ea * eb;
         3'd6, 3'd7: l = 16'hFFFF;
         default: o = '0;
      endcase
      return {o, l};
   endfunction

   logic [21:0] s1, s2;
   always_ff @(posedge clk) begin
      s1 <= alsu_f(alsu_opcode, alsu_A, alsu_B, alsu_ctrl);
      s2 <= s1;
   end
   assign alsu_out  = s2[21:16];
   assign alsu_leds = s2[15:0];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [2:0] va [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3};
   logic [2:0] vb [6] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3};
   logic [5:0] ve [6] = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6};

   logic [2:0] ta [8] = '{3'd0, 3'd1, 3'd2, 3'd3,
                          3'd3, 3'd3, 3'b111, 3'b100};
   logic [2:0] tb [8] = '{3'd1, 3'd1, 3'd1, 3'd1,
                          3'd2, 3'd3, 3'b111, 3'b100};
   logic [5:0] te [8] = '{6'd1, 6'd2, 6'd3, 6'd4,
                          6'd5, 6'd6, 6'h3E, 6'h38};

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int  idx, acc, issued, got, stale;
      logic rdy, a_now, p_now;

      rst = 1'b1; flush = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_opcode = '0; cmd_A = '0; cmd_B = '0; cmd_ctrl = '0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_ready", 32'(cmd_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_out", 32'($unsigned(rsp_out)), 0);
      chk("rst_alsu_op", 32'(alsu_opcode), 0);
      chk("rst_err_cnt", 32'(err_cnt), 0);
      rst = 1'b0;
      #1;
      chk("rel_ready_early", 32'(cmd_ready), 0);
      tick();
      chk("rel_ready", 32'(cmd_ready), 1);

      // ADD 3+2+cin
      rsp_ready = 1'b1;
      cmd_valid = 1'b1; cmd_opcode = 3'd2;
      cmd_A = 3'sd3; cmd_B = 3'sd2; cmd_ctrl = 7'b1000000;
      tick();
      chk("add_alsu_op", 32'(alsu_opcode), 2);
      chk("add_alsu_A", 32'($unsigned(alsu_A)), 3);
      chk("add_alsu_ctrl", 32'(alsu_ctrl), 32'h40);
      cmd_valid = 1'b0;
      tick();
      chk("add_bubble", 32'(alsu_opcode), 0);
      chk("add_n1_valid", 32'(rsp_valid), 0);
      tick();
      chk("add_n2_valid", 32'(rsp_valid), 0);
      tick();
      chk("add_n3_valid", 32'(rsp_valid), 1);
      chk("add_out", 32'($unsigned(rsp_out)), 6);
      chk("add_invalid", 32'(rsp_invalid), 0);
      tick();
      chk("add_popped", 32'(rsp_valid), 0);

      // invalid opcode
      cmd_valid = 1'b1; cmd_opcode = 3'b110;
      cmd_A = 3'sd1; cmd_B = 3'sd1; cmd_ctrl = '0;
      tick();
      cmd_valid = 1'b0;
      repeat (3) tick();
      chk("inv_valid", 32'(rsp_valid), 1);
      chk("inv_out", 32'($unsigned(rsp_out)), 0);
      chk("inv_flag", 32'(rsp_invalid), 1);
      tick();
      chk("inv_err_cnt", 32'(err_cnt), 32'(EXP_ERR));

      // backpressure: 6 offered, 4 accepted
      rsp_ready = 1'b0;
      idx = 0; acc = 0;
      for (int c = 0; c < 12; c++) begin
         cmd_valid = 1'b1; cmd_opcode = 3'd2; cmd_ctrl = '0;
         cmd_A = va[idx]; cmd_B = vb[idx];
         rdy = cmd_ready;
         tick();
         if (rdy) begin
            acc++;
            if (idx < 5) idx++;
         end
      end
      chk("bp_accepted", 32'(acc), 4);
      chk("bp_ready_low", 32'(cmd_ready), 0);
      chk("bp_head0", 32'($unsigned(rsp_out)), 32'(ve[0]));
      cmd_valid = 1'b0; rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("bp_ready_after_pop", 32'(cmd_ready), 1);
      chk("bp_head1", 32'($unsigned(rsp_out)), 32'(ve[1]));
      rsp_ready = 1'b1;
      tick();
      chk("bp_head2", 32'($unsigned(rsp_out)), 32'(ve[2]));
      tick();
      chk("bp_head3", 32'($unsigned(rsp_out)), 32'(ve[3]));
      tick();
      chk("bp_drained", 32'(rsp_valid), 0);

      // streaming after fill
      issued = 0; got = 0;
      for (int c = 0; c < 80 && got < 8; c++) begin
         cmd_valid = (issued < 8);
         cmd_opcode = 3'd2; cmd_ctrl = '0;
         cmd_A = ta[issued[2:0]]; cmd_B = tb[issued[2:0]];
         rsp_ready = (c >= 10);
         a_now = cmd_valid && cmd_ready;
         p_now = rsp_valid && rsp_ready;
         if (p_now) begin
            chk("stream_order", 32'($unsigned(rsp_out)), 32'(te[got[2:0]]));
            got++;
         end
         tick();
         if (a_now) issued++;
      end
      cmd_valid = 1'b0; rsp_ready = 1'b0;
      chk("stream_got", 32'(got), 8);
      chk("stream_issued", 32'(issued), 8);
      chk("stream_empty", 32'(rsp_valid), 0);

      // flush with 2 queued, 2 in flight
      cmd_valid = 1'b1; cmd_opcode = 3'd2; cmd_ctrl = '0;
      cmd_A = 3'sd1; cmd_B = 3'sd0;
      tick();
      cmd_A = 3'sd2;
      tick();
      cmd_valid = 1'b0;
      repeat (3) tick();
      chk("fl_queued", 32'(rsp_valid), 1);
      cmd_valid = 1'b1; cmd_A = 3'sd3;
      tick();
      cmd_A = -3'sd1;
      tick();
      cmd_valid = 1'b0; flush = 1'b1;
      chk("fl_ready_gated", 32'(cmd_ready), 0);
      tick();
      flush = 1'b0;
      chk("fl_rsp_dropped", 32'(rsp_valid), 0);
      cmd_valid = 1'b1; cmd_A = 3'sd1; cmd_B = 3'sd1;
      chk("fl_ready_c0", 32'(cmd_ready), 0);
      stale = 0;
      tick();
      stale += int'(rsp_valid);
      chk("fl_ready_c1", 32'(cmd_ready), 0);
      tick();
      stale += int'(rsp_valid);
      chk("fl_ready_c2", 32'(cmd_ready), 0);
      tick();
      stale += int'(rsp_valid);
      chk("fl_ready_c3", 32'(cmd_ready), 1);
      rsp_ready = 1'b1;
      tick();
      cmd_valid = 1'b0;
      stale += int'(rsp_valid);
      tick();
      stale += int'(rsp_valid);
      tick();
      stale += int'(rsp_valid);
      tick();
      chk("fl_no_stale", 32'(stale), 0);
      chk("fl_new_valid", 32'(rsp_valid), 1);
      chk("fl_new_out", 32'($unsigned(rsp_out)), 2);
      tick();
      chk("fl_new_popped", 32'(rsp_valid), 0);
      chk("fl_err_kept", 32'(err_cnt), 32'(EXP_ERR));

      // reset mid-stream
      rsp_ready = 1'b0;
      cmd_valid = 1'b1; cmd_opcode = 3'b110; cmd_A = 3'sd1; cmd_B = 3'sd1;
      repeat (4) tick();
      rsp_ready = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      chk("mid_cmd_ready", 32'(cmd_ready), 0);
      chk("mid_rsp_valid", 32'(rsp_valid), 0);
      chk("mid_rsp_out", 32'($unsigned(rsp_out)), 0);
      chk("mid_rsp_inv", 32'(rsp_invalid), 0);
      chk("mid_alsu_op", 32'(alsu_opcode), 0);
      chk("mid_alsu_ctrl", 32'(alsu_ctrl), 0);
      chk("mid_err_cnt", 32'(err_cnt), 0);
      cmd_valid = 1'b0; rsp_ready = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      chk("post_ready", 32'(cmd_ready), 1);
      chk("post_no_rsp", 32'(rsp_valid), 0);
      cmd_valid = 1'b1; cmd_opcode = 3'd2;
      cmd_A = 3'sd2; cmd_B = 3'sd1; cmd_ctrl = 7'b1000000;
      tick();
      cmd_valid = 1'b0;
      stale = 0;
      tick();
      stale += int'(rsp_valid);
      tick();
      stale += int'(rsp_valid);
      tick();
      chk("post_no_stale", 32'(stale), 0);
      chk("post_valid", 32'(rsp_valid), 1);
      chk("post_out", 32'($unsigned(rsp_out)), 4);
      chk("post_inv", 32'(rsp_invalid), 0);
      rsp_ready = 1'b1;
      tick();
      chk("post_popped", 32'(rsp_valid), 0);
      chk("post_err_cnt", 32'(err_cnt), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
